// File: rtl/osc_capture_pkg.sv
// Shared types, defaults and modular-address helper for the oscilloscope
// acquisition stage.
package osc_capture_pkg;

  // Acquisition FSM states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } capture_state_t;

  // Default frame geometry: one sample per VGA column, trigger centred.
  localparam int DEPTH_DEF   = 640;
  localparam int PRETRIG_DEF = 320;

  // Working width of the wrap helper; callers zero-extend their
  // ADDR_W+1-bit operands into it, so ADDR_W must stay below WRAP_W.
  localparam int WRAP_W = 16;

  // (a + b) mod modulus, valid when both a and b are at most modulus, so a
  // single conditional subtraction is enough.
  function automatic logic [WRAP_W-1:0] wrap_add(
    input logic [WRAP_W-1:0] a,
    input logic [WRAP_W-1:0] b,
    input logic [WRAP_W-1:0] modulus
  );
    logic [WRAP_W-1:0] s;
    s = a + b;
    if (s >= modulus) begin
      s = s - modulus;
    end
    return s;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one synchronous write port, one read port
// with a registered output. Contents are deliberately not reset.
module capture_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_rdata;

  // Write port: store the sample when the capture logic enables it.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: registered read so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/osc_sample_capture.sv
// Oscilloscope acquisition: sample-clock synchronizer and tick generator,
// circular capture buffer with level/slope trigger, fixed pre-trigger depth
// and a frozen frame readable by logical column.
module osc_sample_capture
  import osc_capture_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = 10,
  parameter int PRETRIG = PRETRIG_DEF
) (
  input  logic              inclk,
  input  logic              Reset,
  input  logic              sample_clk,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              armed,
  output logic              triggered,
  output logic              frame_ready
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] ONE_N   = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRE_N   = CNT_W'(PRETRIG);
  localparam logic [CNT_W-1:0] POST_N  = CNT_W'(DEPTH - PRETRIG);
  localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(DEPTH);

  // (a + b) mod DEPTH on buffer addresses, both operands at most DEPTH.
  function automatic logic [ADDR_W-1:0] mod_add(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b
  );
    logic [WRAP_W-1:0] s;
    s = wrap_add(WRAP_W'(a), WRAP_W'(b), WRAP_W'(DEPTH));
    return s[ADDR_W-1:0];
  endfunction

  // Synchronizer / tick
  logic [2:0]         r_sync;
  logic               r_tick;

  // FSM and pointers
  capture_state_t     r_state;
  capture_state_t     w_state_next;
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  w_wr_ptr_next;
  logic [ADDR_W-1:0]  w_wr_ptr_inc;
  logic [CNT_W-1:0]   r_pre_cnt;
  logic [CNT_W-1:0]   w_pre_cnt_next;
  logic [CNT_W-1:0]   r_post_cnt;
  logic [CNT_W-1:0]   w_post_cnt_next;
  logic [ADDR_W-1:0]  r_trig_ptr;
  logic [ADDR_W-1:0]  w_trig_ptr_next;
  logic [DATA_W-1:0]  r_prev_sample;
  logic               w_we;
  logic               w_crossing;

  // Status and read path
  logic               r_armed;
  logic               r_triggered;
  logic               r_frame_ready;
  logic               w_rd_oob;
  logic [ADDR_W-1:0]  w_start_ptr;
  logic [ADDR_W-1:0]  w_rd_phys;
  logic [DATA_W-1:0]  w_ram_q;
  logic               r_rd_zero;

  // Two-stage synchronizer plus history flop; the tick is a registered rising edge.
  always_ff @(posedge inclk) begin
    if (!Reset) begin
      r_sync <= '0;
      r_tick <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], sample_clk};
      r_tick <= r_sync[1] & ~r_sync[2];
    end
  end

  // Crossing test against the last written sample; comparisons are unsigned.
  always_comb begin
    if (trig_slope) begin
      w_crossing = (r_prev_sample < trig_level) && (adc_data >= trig_level);
    end else begin
      w_crossing = (r_prev_sample > trig_level) && (adc_data <= trig_level);
    end
  end

  // Next-state, pointer and write-enable logic; arm overrides everything.
  always_comb begin
    w_state_next    = r_state;
    w_wr_ptr_next   = r_wr_ptr;
    w_pre_cnt_next  = r_pre_cnt;
    w_post_cnt_next = r_post_cnt;
    w_trig_ptr_next = r_trig_ptr;
    w_we            = 1'b0;
    w_wr_ptr_inc    = mod_add({1'b0, r_wr_ptr}, ONE_N);

    if (arm) begin
      // A tick coinciding with arm is dropped on purpose.
      w_state_next   = PRE;
      w_wr_ptr_next  = '0;
      w_pre_cnt_next = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
        end
        PRE: begin
          if (r_tick) begin
            w_we           = 1'b1;
            w_wr_ptr_next  = w_wr_ptr_inc;
            w_pre_cnt_next = r_pre_cnt + ONE_N;
          end
          if ((PRE_N == '0) || (r_tick && ((r_pre_cnt + ONE_N) == PRE_N))) begin
            w_state_next = WAIT;
          end
        end
        WAIT: begin
          if (r_tick) begin
            w_we          = 1'b1;
            w_wr_ptr_next = w_wr_ptr_inc;
          end
          if (r_tick && w_crossing) begin
            // The sample being written now is the trigger sample.
            w_trig_ptr_next = r_wr_ptr;
            w_post_cnt_next = ONE_N;
            w_state_next    = (POST_N == ONE_N) ? DONE : POST;
          end else if (force_trig) begin
            // Forced trigger: the trigger sample is the next one written.
            w_trig_ptr_next = r_tick ? w_wr_ptr_inc : r_wr_ptr;
            w_post_cnt_next = '0;
            w_state_next    = POST;
          end
        end
        POST: begin
          if (r_tick) begin
            w_we            = 1'b1;
            w_wr_ptr_next   = w_wr_ptr_inc;
            w_post_cnt_next = r_post_cnt + ONE_N;
            if ((r_post_cnt + ONE_N) == POST_N) begin
              w_state_next = DONE;
            end
          end
        end
        DONE: begin
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // FSM, pointer and last-sample registers.
  always_ff @(posedge inclk) begin
    if (!Reset) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_pre_cnt     <= '0;
      r_post_cnt    <= '0;
      r_trig_ptr    <= '0;
      r_prev_sample <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wr_ptr   <= w_wr_ptr_next;
      r_pre_cnt  <= w_pre_cnt_next;
      r_post_cnt <= w_post_cnt_next;
      r_trig_ptr <= w_trig_ptr_next;
      if (w_we) begin
        r_prev_sample <= adc_data;
      end
    end
  end

  // Status flags follow the state register one cycle later.
  always_ff @(posedge inclk) begin
    if (!Reset) begin
      r_armed       <= 1'b0;
      r_triggered   <= 1'b0;
      r_frame_ready <= 1'b0;
    end else begin
      r_armed       <= (r_state == PRE)  || (r_state == WAIT);
      r_triggered   <= (r_state == POST) || (r_state == DONE);
      r_frame_ready <= (r_state == DONE);
    end
  end

  // Logical column to physical address: the frame starts PRETRIG samples
  // before the trigger, i.e. trig_ptr + (DEPTH - PRETRIG) modulo DEPTH.
  always_comb begin
    w_rd_oob    = ({1'b0, rd_addr} >= DEPTH_N);
    w_start_ptr = mod_add({1'b0, r_trig_ptr}, POST_N);
    w_rd_phys   = w_rd_oob ? '0 : mod_add({1'b0, w_start_ptr}, {1'b0, rd_addr});
  end

  // Out-of-range columns (and the reset state) force the output to zero.
  always_ff @(posedge inclk) begin
    if (!Reset) begin
      r_rd_zero <= 1'b1;
    end else begin
      r_rd_zero <= w_rd_oob;
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (inclk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (adc_data),
    .i_raddr (w_rd_phys),
    .o_rdata (w_ram_q)
  );

  assign rd_data     = r_rd_zero ? '0 : w_ram_q;
  assign armed       = r_armed;
  assign triggered   = r_triggered;
  assign frame_ready = r_frame_ready;

endmodule

// File: tb/tb_osc_sample_capture.sv
// Directed bench for osc_sample_capture: stimulus pushes expected results
// into a scoreboard; a monitor pops and compares one cycle after each request.
module tb_osc_sample_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_clk = 1'b0;
  logic [7:0] adc_data = 8'h00;
  logic [7:0] trig_level = 8'h80;
  logic       trig_slope = 1'b1;
  logic       arm = 1'b0;
  logic       force_trig = 1'b0;
  logic [9:0] rd_addr = 10'd0;
  logic [7:0] rd_data;
  logic       armed;
  logic       triggered;
  logic       frame_ready;

  int checks = 0;
  int errors = 0;

  // Scoreboard: kind 0 = rd_data, kind 1 = {armed,triggered,frame_ready}.
  int         exp_kind_q[$];
  logic [7:0] exp_val_q[$];
  string      exp_name_q[$];
  logic       req = 1'b0;
  logic       req_q = 1'b0;

  osc_sample_capture dut (
    .inclk       (clk),
    .Reset       (rst_n),
    .sample_clk  (sample_clk),
    .adc_data    (adc_data),
    .trig_level  (trig_level),
    .trig_slope  (trig_slope),
    .arm         (arm),
    .force_trig  (force_trig),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .armed       (armed),
    .triggered   (triggered),
    .frame_ready (frame_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) req_q <= req;

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    if (req_q) begin
      checks++;
      if (exp_val_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got a request with no expectation queued");
      end else begin
        int         k;
        logic [7:0] v;
        logic [7:0] act;
        string      nm;
        k  = exp_kind_q.pop_front();
        v  = exp_val_q.pop_front();
        nm = exp_name_q.pop_front();
        act = (k == 0) ? rd_data : {5'b0, armed, triggered, frame_ready};
        if (act !== v) begin
          errors++;
          $display("FAIL %s: got %02h expected %02h", nm, act, v);
        end
      end
    end
  end

  // All tasks start and end on a falling edge.
  task automatic chk(input int kind, input int addr, input logic [7:0] exp, input string nm);
    rd_addr = 10'(addr);
    exp_kind_q.push_back(kind);
    exp_val_q.push_back(exp);
    exp_name_q.push_back(nm);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic stat(input logic [2:0] exp, input string nm);
    chk(1, 0, {5'b0, exp}, nm);
  endtask

  task automatic do_tick(input logic [7:0] d);
    adc_data   = d;
    sample_clk = 1'b1;
    repeat (2) @(negedge clk);
    sample_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pulse_force();
    force_trig = 1'b1;
    @(negedge clk);
    force_trig = 1'b0;
  endtask

  // Hand-derived frame contents for each scenario, by logical column k.
  function automatic logic [7:0] frame_exp(input int mode, input int k);
    int idx;
    case (mode)
      2:       frame_exp = 8'((64 + k) % 256);          // rising ramp, trigger idx 384
      3:       frame_exp = 8'(255 - ((127 + k) % 256)); // falling ramp, trigger idx 447
      4:       frame_exp = 8'h22;
      default: begin                                     // wrap test, trigger idx 740
        idx = 420 + k;
        frame_exp = (idx < 740) ? 8'(idx % 64) : 8'(8'h80 + (idx % 64));
      end
    endcase
  endfunction

  task automatic frame_chk(input int mode, input string nm);
    for (int k = 0; k < 640; k++) begin
      chk(0, k, frame_exp(mode, k), $sformatf("%s col%0d", nm, k));
    end
  endtask

  function automatic logic [7:0] wrap_data(input int i);
    return (i < 740) ? 8'(i % 64) : 8'(8'h80 + (i % 64));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk(0, 5, 8'h00, "reset rd_data");
    stat(3'b000, "reset status");
    rst_n = 1'b1;
    @(negedge clk);
    $display("phase reset: done");

    // Constant 0x10, level 0x80: no trigger, stays armed
    pulse_force();
    stat(3'b000, "force in IDLE ignored");
    trig_level = 8'h80; trig_slope = 1'b1;
    pulse_arm();
    stat(3'b100, "t1 armed after arm");
    for (int i = 0; i < 340; i++) do_tick(8'h10);
    stat(3'b100, "t1 waiting no trigger");
    $display("phase const: 340 ticks of 0x10");

    // Rising ramp, level 0x80: trigger at index 384 (crossing at 128 is in PRE)
    pulse_arm();
    for (int i = 0; i < 703; i++) do_tick(8'(i % 256));
    stat(3'b010, "t2 post before last");
    do_tick(8'(703 % 256));
    stat(3'b011, "t2 done");
    for (int i = 0; i < 5; i++) do_tick(8'hEE);
    stat(3'b011, "t2 frozen");
    chk(0, 320, 8'h80, "t2 rd320");
    chk(0, 319, 8'h7F, "t2 rd319");
    frame_chk(2, "t2");
    $display("phase ramp rising: frame checked");

    // Falling ramp, level 0x40: trigger at index 447
    trig_level = 8'h40; trig_slope = 1'b0;
    pulse_arm();
    for (int i = 0; i < 767; i++) do_tick(8'(255 - (i % 256)));
    stat(3'b011, "t3 done");
    chk(0, 320, 8'h40, "t3 rd320");
    chk(0, 319, 8'h41, "t3 rd319");
    frame_chk(3, "t3");
    $display("phase ramp falling: frame checked");

    // Forced trigger with constant 0x22; force in PRE is ignored
    trig_level = 8'h80; trig_slope = 1'b1;
    pulse_arm();
    for (int i = 0; i < 100; i++) do_tick(8'h22);
    pulse_force();
    stat(3'b100, "t4 force in PRE ignored");
    for (int i = 0; i < 220; i++) do_tick(8'h22);
    stat(3'b100, "t4 waiting");
    pulse_force();
    stat(3'b010, "t4 forced");
    for (int i = 0; i < 319; i++) do_tick(8'h22);
    stat(3'b010, "t4 post before last");
    do_tick(8'h22);
    stat(3'b011, "t4 done");
    frame_chk(4, "t4");
    $display("phase force: frame checked");

    // arm mid-POST restarts, then re-triggers on the ramp
    pulse_arm();
    for (int i = 0; i < 400; i++) do_tick(8'(i % 256));
    stat(3'b010, "t5 in post");
    pulse_arm();
    stat(3'b100, "t5 rearmed");
    for (int i = 0; i < 704; i++) do_tick(8'(i % 256));
    stat(3'b011, "t5 done");
    chk(0, 320, 8'h80, "t5 rd320");
    chk(0, 319, 8'h7F, "t5 rd319");
    chk(0, 0, 8'h40, "t5 rd0");
    $display("phase rearm: checked");

    // Reset mid-POST returns to IDLE; no capture without a new arm
    pulse_arm();
    for (int i = 0; i < 400; i++) do_tick(8'(i % 256));
    stat(3'b010, "t6 in post");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stat(3'b000, "t6 after reset");
    for (int i = 0; i < 10; i++) do_tick(8'h55);
    stat(3'b000, "t6 idle stays");
    $display("phase reset mid-post: checked");

    // Write-pointer wrap: trigger at physical 100, frame starts at 420
    pulse_arm();
    for (int i = 0; i < 1060; i++) do_tick(wrap_data(i));
    stat(3'b011, "t7 done");
    chk(0, 0,    8'h24, "t7 rd0");
    chk(0, 319,  8'h23, "t7 rd319");
    chk(0, 320,  8'hA4, "t7 rd320");
    chk(0, 639,  8'hA3, "t7 rd639");
    chk(0, 700,  8'h00, "t7 rd700");
    chk(0, 1023, 8'h00, "t7 rd1023");
    chk(0, 640,  8'h00, "t7 rd640");
    frame_chk(6, "t7");
    $display("phase wrap: frame checked");

    repeat (4) @(negedge clk);
    if (exp_val_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_val_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
